// File: rtl/pc_gen_pkg.sv
// Shared defaults and types for the PC generation unit: parameter defaults,
// redirect-source encoding and the checkpoint entry layout.
package pc_gen_pkg;

  localparam int unsigned            DEF_XLEN       = 32;
  localparam logic [DEF_XLEN-1:0]    DEF_RESET_PC   = 32'h0;
  localparam int unsigned            DEF_CKPT_DEPTH = 4;
  localparam int unsigned            DEF_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    JB      = 2'd1,
    MISPRED = 2'd2
  } redir_src_e;

  // A checkpoint is the fall-through PC of a predicted-taken branch, i.e. the
  // address fetch must restart from if that branch turns out not taken.
  typedef struct packed {
    logic [DEF_XLEN-1:0] fall_through;
  } ckpt_entry_t;

  function automatic int unsigned ckpt_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch-control bundle between the pipeline (master) and the PC generator
// (slave): stall/prediction/redirect inputs and PC/flush/checkpoint status.
interface pc_gen_unit_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned CKPT_DEPTH = DEF_CKPT_DEPTH
);

  logic                            i_stall;
  logic                            i_pred_valid;
  logic [XLEN-1:0]                 i_pred_pc;
  logic                            i_jb_valid;
  logic [XLEN-1:0]                 i_jb_pc;
  logic                            i_res_valid;
  logic                            i_res_mispred;

  logic [XLEN-1:0]                 o_pc;
  logic [XLEN-1:0]                 o_addr;
  logic                            o_pred_taken;
  logic                            o_flush;
  logic                            o_fetch_en;
  logic                            o_ckpt_full;
  logic [$clog2(CKPT_DEPTH):0]     o_ckpt_count;
  logic                            o_underflow;

  modport master (
    output i_stall, i_pred_valid, i_pred_pc, i_jb_valid, i_jb_pc,
           i_res_valid, i_res_mispred,
    input  o_pc, o_addr, o_pred_taken, o_flush, o_fetch_en,
           o_ckpt_full, o_ckpt_count, o_underflow
  );

  modport slave (
    input  i_stall, i_pred_valid, i_pred_pc, i_jb_valid, i_jb_pc,
           i_res_valid, i_res_mispred,
    output o_pc, o_addr, o_pred_taken, o_flush, o_fetch_en,
           o_ckpt_full, o_ckpt_count, o_underflow
  );

endinterface

// File: rtl/pc_gen_unit_ckpt_fifo.sv
// Checkpoint FIFO: holds fall-through PCs of outstanding predicted-taken
// branches in program order, with a whole-queue clear for redirects.
module ckpt_fifo
  import pc_gen_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_CKPT_DEPTH,
  parameter int unsigned WIDTH = DEF_XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which slots
  // are meaningful, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// PC generator: fetch PC register, prediction acceptance, checkpointing of
// predicted-taken branches and redirect (flush) handling for stalls.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter int unsigned     CKPT_DEPTH = DEF_CKPT_DEPTH,
  parameter int unsigned     ADDR_SHIFT = DEF_ADDR_SHIFT
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(CKPT_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d, pc_seq;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            fetch_en_q, fetch_en_d;
  logic            underflow_q, underflow_d;

  redir_src_e      redir_src;
  logic            redir_in;
  logic [XLEN-1:0] redir_tgt;
  logic            pred_taken;

  logic [XLEN-1:0] ckpt_head;
  logic [CW-1:0]   ckpt_count;
  logic            ckpt_full, ckpt_empty, ckpt_pop;

  assign pc_seq = pc_q + XLEN'(4);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    redir_src = NONE;
    if (bus.i_res_valid && bus.i_res_mispred && !ckpt_empty) redir_src = MISPRED;
    else if (bus.i_jb_valid)                                 redir_src = JB;
  end

  assign redir_in  = (redir_src != NONE);
  assign redir_tgt = (redir_src == MISPRED) ? ckpt_head : bus.i_jb_pc;

  assign pred_taken = bus.i_pred_valid && !bus.i_stall && !pend_valid_q &&
                      !redir_in && !ckpt_full;
  assign ckpt_pop   = bus.i_res_valid && !ckpt_empty;

  always_comb begin
    pc_d = pc_q;
    if (pend_valid_q && !bus.i_stall) pc_d = pend_tgt_q;
    else if (bus.i_stall)             pc_d = pc_q;
    else if (pred_taken)              pc_d = bus.i_pred_pc;
    else                              pc_d = pc_seq;
  end

  // A newer redirect replaces an older one even while the pipe is stalled.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (redir_in) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = redir_tgt;
    end else if (pend_valid_q && !bus.i_stall) begin
      pend_valid_d = 1'b0;
    end
  end

  assign fetch_en_d  = fetch_en_q || !bus.i_stall;
  assign underflow_d = underflow_q || (bus.i_res_valid && ckpt_empty);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
      fetch_en_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      fetch_en_q   <= fetch_en_d;
      underflow_q  <= underflow_d;
    end
  end

  ckpt_fifo #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (XLEN)
  ) u_ckpt_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pred_taken),
    .pop_i   (ckpt_pop),
    .clear_i (redir_in),
    .data_i  (pc_seq),
    .head_o  (ckpt_head),
    .count_o (ckpt_count),
    .full_o  (ckpt_full),
    .empty_o (ckpt_empty)
  );

  assign bus.o_pc         = pc_q;
  assign bus.o_addr       = pc_q >> ADDR_SHIFT;
  assign bus.o_pred_taken = pred_taken;
  assign bus.o_flush      = pend_valid_q;
  assign bus.o_fetch_en   = fetch_en_q;
  assign bus.o_ckpt_full  = ckpt_full;
  assign bus.o_ckpt_count = ckpt_count;
  assign bus.o_underflow  = underflow_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vector table, reset-in-flight sequences and
// a randomized run compared against a queue-based reference model.
module tb_pc_gen_unit;
  import pc_gen_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_unit_if #(.XLEN(32), .CKPT_DEPTH(DEPTH)) bus ();

  pc_gen_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0),
    .CKPT_DEPTH (DEPTH),
    .ADDR_SHIFT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        st, pv;
    logic [31:0] ppc;
    logic        jv;
    logic [31:0] jpc;
    logic        rv, rm;
    logic        e_pt;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_fl, e_fe, e_uf;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_pc, m_tgt;
  bit          m_pend, m_fe, m_uf;
  ckpt_entry_t m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic pv, input logic [31:0] ppc,
                       input logic jv, input logic [31:0] jpc,
                       input logic rv, input logic rm);
    bus.i_stall       = st;
    bus.i_pred_valid  = pv;
    bus.i_pred_pc     = ppc;
    bus.i_jb_valid    = jv;
    bus.i_jb_pc       = jpc;
    bus.i_res_valid   = rv;
    bus.i_res_mispred = rm;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input int cnt,
                             input logic fl, input logic fe, input logic uf);
    check($sformatf("%s.pc", tag),    bus.o_pc, pc);
    check($sformatf("%s.addr", tag),  bus.o_addr, pc >> 2);
    check($sformatf("%s.count", tag), 32'(bus.o_ckpt_count), 32'(cnt));
    check($sformatf("%s.full", tag),  32'(bus.o_ckpt_full), 32'(cnt == DEPTH));
    check($sformatf("%s.flush", tag), 32'(bus.o_flush), 32'(fl));
    check($sformatf("%s.fe", tag),    32'(bus.o_fetch_en), 32'(fe));
    check($sformatf("%s.uf", tag),    32'(bus.o_underflow), 32'(uf));
  endtask

  // Starts and ends at a falling edge: drive, check the combinational
  // prediction accept, take one rising edge, check registered state.
  task automatic run(input string tag, input vec_t v);
    drive(v.st, v.pv, v.ppc, v.jv, v.jpc, v.rv, v.rm);
    #1;
    check($sformatf("%s.pt", tag), 32'(bus.o_pred_taken), 32'(v.e_pt));
    @(posedge clk);
    #1;
    check_state(tag, v.e_pc, v.e_cnt, v.e_fl, v.e_fe, v.e_uf);
    @(negedge clk);
  endtask

  task automatic add(input logic st, input logic pv, input logic [31:0] ppc,
                     input logic jv, input logic [31:0] jpc, input logic rv, input logic rm,
                     input logic ept, input logic [31:0] epc, input int ecnt,
                     input logic efl, input logic efe, input logic euf);
    vec_t v;
    v.st = st; v.pv = pv; v.ppc = ppc; v.jv = jv; v.jpc = jpc; v.rv = rv; v.rm = rm;
    v.e_pt = ept; v.e_pc = epc; v.e_cnt = ecnt; v.e_fl = efl; v.e_fe = efe; v.e_uf = euf;
    vecs.push_back(v);
  endtask

  function automatic vec_t mk(input logic st, input logic pv, input logic [31:0] ppc,
                              input logic jv, input logic [31:0] jpc, input logic rv,
                              input logic rm, input logic ept, input logic [31:0] epc,
                              input int ecnt, input logic efl, input logic efe,
                              input logic euf);
    vec_t v;
    v.st = st; v.pv = pv; v.ppc = ppc; v.jv = jv; v.jpc = jpc; v.rv = rv; v.rm = rm;
    v.e_pt = ept; v.e_pc = epc; v.e_cnt = ecnt; v.e_fl = efl; v.e_fe = efe; v.e_uf = euf;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_tgt = 32'h0; m_pend = 0; m_fe = 0; m_uf = 0;
    m_q.delete();
  endtask

  task automatic random_step(input int idx);
    logic        st, pv, jv, rv, rm, mis, redir, ept;
    logic [31:0] ppc, jpc, tgt, nxt;
    ckpt_entry_t e;
    st  = ($urandom_range(0, 3) == 0);
    pv  = ($urandom_range(0, 9) < 4);
    ppc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    jv  = ($urandom_range(0, 11) == 0);
    jpc = $urandom() & 32'hFFFF_FFFC;
    rv  = ($urandom_range(0, 4) == 0);
    rm  = 1'($urandom_range(0, 1));
    drive(st, pv, ppc, jv, jpc, rv, rm);

    mis   = rv && rm && (m_q.size() != 0);
    redir = mis || jv;
    tgt   = mis ? m_q[0].fall_through : jpc;
    ept   = pv && !st && !m_pend && !redir && (m_q.size() != DEPTH);
    #1;
    check($sformatf("rnd%0d.pt", idx), 32'(bus.o_pred_taken), 32'(ept));
    @(posedge clk);

    if (m_pend && !st) nxt = m_tgt;
    else if (st)       nxt = m_pc;
    else if (ept)      nxt = ppc;
    else               nxt = m_pc + 32'd4;
    m_uf = m_uf || (rv && m_q.size() == 0);
    if (redir) begin
      m_q.delete();
    end else begin
      if (rv && m_q.size() != 0) void'(m_q.pop_front());
      if (ept) begin
        e.fall_through = m_pc + 32'd4;
        m_q.push_back(e);
      end
    end
    if (redir)               begin m_pend = 1; m_tgt = tgt; end
    else if (m_pend && !st)  m_pend = 0;
    m_fe = m_fe || !st;
    m_pc = nxt;

    #1;
    check_state($sformatf("rnd%0d", idx), m_pc, m_q.size(), m_pend, m_fe, m_uf);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // st pv ppc  jv jpc  rv rm | pt pc  cnt fl fe uf
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h4,  0,0,1,0);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h8,  0,0,1,0);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'hC,  0,0,1,0);
    add(0,0,32'h0,  1,32'h100,0,0, 0,32'h10, 0,1,1,0);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h100,0,0,1,0);
    add(0,1,32'h200,0,32'h0,  0,0, 1,32'h200,1,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,1, 0,32'h204,0,1,1,0);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h104,0,0,1,0);
    add(0,1,32'h300,0,32'h0,  0,0, 1,32'h300,1,0,1,0);
    add(0,1,32'h400,0,32'h0,  0,0, 1,32'h400,2,0,1,0);
    add(0,1,32'h500,0,32'h0,  0,0, 1,32'h500,3,0,1,0);
    add(0,1,32'h600,0,32'h0,  0,0, 1,32'h600,4,0,1,0);
    add(0,1,32'h700,0,32'h0,  0,0, 0,32'h604,4,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,0, 0,32'h608,3,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,0, 0,32'h60C,2,0,1,0);
    add(0,1,32'h800,0,32'h0,  1,0, 1,32'h800,2,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,0, 0,32'h804,1,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,0, 0,32'h808,0,0,1,0);
    add(0,0,32'h0,  0,32'h0,  1,0, 0,32'h80C,0,0,1,1);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h810,0,0,1,1);
    add(1,0,32'h0,  1,32'h40, 0,0, 0,32'h810,0,1,1,1);
    add(1,1,32'h900,0,32'h0,  0,0, 0,32'h810,0,1,1,1);
    add(1,0,32'h0,  0,32'h0,  0,0, 0,32'h810,0,1,1,1);
    add(0,1,32'h950,0,32'h0,  0,0, 0,32'h40, 0,0,1,1);
    add(0,1,32'hA00,0,32'h0,  0,0, 1,32'hA00,1,0,1,1);
    add(0,0,32'h0,  1,32'h50, 1,1, 0,32'hA04,0,1,1,1);
    add(0,0,32'h0,  0,32'h0,  0,0, 0,32'h44, 0,0,1,1);

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_state("reset", 32'h0, 0, 0, 0, 0);
    check("reset.pt", 32'(bus.o_pred_taken), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

    // Reset arriving mid-cycle with three checkpoints and a redirect incoming
    run("seqA0", mk(0,1,32'h1000,0,0,0,0, 1,32'h1000,1,0,1,1));
    run("seqA1", mk(0,1,32'h2000,0,0,0,0, 1,32'h2000,2,0,1,1));
    run("seqA2", mk(0,1,32'h3000,0,0,0,0, 1,32'h3000,3,0,1,1));
    drive(0, 0, 0, 1, 32'h77C, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_state("seqA.rst", 32'h0, 0, 0, 0, 0);
    check("seqA.rst.pt", 32'(bus.o_pred_taken), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run("seqA3", mk(0,0,0,0,0,0,0, 0,32'h4,0,0,1,0));
    run("seqA4", mk(0,0,0,0,0,0,0, 0,32'h8,0,0,1,0));

    // Reset while a redirect is pending behind a stall
    run("seqB0", mk(1,0,0,1,32'h500,0,0, 0,32'h8,0,1,1,0));
    drive(1, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check_state("seqB.rst", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run("seqB1", mk(0,0,0,0,0,0,0, 0,32'h4,0,0,1,0));
    run("seqB2", mk(0,0,0,0,0,0,0, 0,32'h8,0,0,1,0));

    // Randomized run against the reference model
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2000; i++) random_step(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
